// File: rtl/relu_stream_ctrl.sv
// Sequencer for the 2-stage ReLU unit: streams NUM_CH feature maps of MAP_LEN elements.
// Optional negative-input counter is enabled with `define RELU_NEG_CNT_EN.
module relu_stream_ctrl #(
  parameter int MAP_LEN = 784,
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 16,
  parameter int CH_W    = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            ch_done,
  output logic [CH_W-1:0] ch_idx,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_neg,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            act_clr,
  output logic            en_act,
  output logic            en_act_out
`ifdef RELU_NEG_CNT_EN
  ,
  output logic [CNT_W-1:0] neg_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(MAP_LEN - 1);
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic             xv, yv;
  logic [CNT_W-1:0] in_cnt, out_cnt;
  logic             y_take;

  assign y_take     = yv & out_ready;
  assign en_act_out = xv & (~yv | out_ready);
  assign in_ready   = (state == RUN) & (~xv | en_act_out);
  assign en_act     = in_valid & in_ready;
  assign out_valid  = yv;
  assign out_last   = yv & (out_cnt == LAST);

`ifndef RELU_NEG_CNT_EN
  logic unused_in_neg;
  assign unused_in_neg = in_neg;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      xv      <= 1'b0;
      yv      <= 1'b0;
      in_cnt  <= '0;
      out_cnt <= '0;
      ch_idx  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ch_done <= 1'b0;
      act_clr <= 1'b0;
`ifdef RELU_NEG_CNT_EN
      neg_cnt <= '0;
`endif
    end else begin
      xv      <= en_act | (xv & ~en_act_out);
      yv      <= en_act_out | (yv & ~out_ready);
      done    <= 1'b0;
      ch_done <= 1'b0;
      act_clr <= 1'b0;
      if (en_act)  in_cnt  <= in_cnt + 1'b1;
      if (y_take)  out_cnt <= out_cnt + 1'b1;
`ifdef RELU_NEG_CNT_EN
      if (en_act && in_neg) neg_cnt <= neg_cnt + 1'b1;
`endif
      case (state)
        IDLE: if (start) begin
          state   <= CLR;
          act_clr <= 1'b1;
          busy    <= 1'b1;
        end
        CLR: begin
          in_cnt  <= '0;
          out_cnt <= '0;
`ifdef RELU_NEG_CNT_EN
          neg_cnt <= '0;
`endif
          state   <= RUN;
        end
        RUN: if (en_act && in_cnt == LAST) state <= DRAIN;
        // The final take of a channel always lands here: every element is already in.
        DRAIN: if (y_take && out_cnt == LAST) begin
          if (ch_idx < CH_LAST) begin
            ch_done <= 1'b1;
            ch_idx  <= ch_idx + 1'b1;
            act_clr <= 1'b1;
            state   <= CLR;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          ch_idx <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Scoreboard bench for relu_stream_ctrl with a behavioural ReLU datapath in the loop.
module tb_relu_stream_ctrl;
  localparam int MAP_LEN = 4, NUM_CH = 2, CNT_W = 8, CH_W = 4;

  logic clk = 0, clr = 0, start = 0, in_valid = 0, in_neg = 0, out_ready = 0;
  logic busy, done, ch_done, in_ready, out_valid, out_last, act_clr, en_act, en_act_out;
  logic [CH_W-1:0] ch_idx;
`ifdef RELU_NEG_CNT_EN
  logic [CNT_W-1:0] neg_cnt;
`endif
  logic signed [7:0] din = 0, xr = 0, yr = 0, prev_y = 0;

  always #5 clk = ~clk;

  relu_stream_ctrl #(.MAP_LEN(MAP_LEN), .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk(clk), .clr(clr), .start(start), .busy(busy), .done(done), .ch_done(ch_done),
    .ch_idx(ch_idx), .in_valid(in_valid), .in_ready(in_ready), .in_neg(in_neg),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .act_clr(act_clr),
    .en_act(en_act), .en_act_out(en_act_out)
`ifdef RELU_NEG_CNT_EN
    , .neg_cnt(neg_cnt)
`endif
  );

  // The ReLU unit this controller sequences: X captures input, Y captures max(X,0).
  always @(posedge clk) begin
    if (act_clr) begin
      xr <= 0;
      yr <= 0;
    end else begin
      if (en_act)     xr <= din;
      if (en_act_out) yr <= (xr < 0) ? 8'sd0 : xr;
    end
  end

  typedef struct {logic signed [7:0] d; logic last; int ch;} exp_t;
  exp_t q[$];
  exp_t e;
  int fq[$];
  int vecs = 0, errs = 0;
  int k = 0, c = 0, neg_acc = 0, last_neg = 0;
  int cyc = 0, t_clr0 = -1, t_done = -1, n_done = 0, n_chd = 0;
  bit prev_stall = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations on output handshakes, pushes them on input handshakes.
  always @(negedge clk) begin
    cyc++;
    if (clr) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_data", yr, e.d);
          chk("out_last", out_last, e.last);
          chk("out_ch", ch_idx, e.ch);
        end
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", yr, prev_y);
      end
      prev_stall = out_valid && !out_ready;
      prev_y = yr;
      if (in_valid && in_ready) begin
        e.d = (din < 0) ? 8'sd0 : din;
        e.last = (k == MAP_LEN - 1);
        e.ch = c;
        q.push_back(e);
        if (fq.size() > 0) void'(fq.pop_front());
        if (din < 0) neg_acc++;
        k++;
        if (k == MAP_LEN) begin
          k = 0; c++; last_neg = neg_acc; neg_acc = 0;
        end
      end
      if (act_clr) begin
        if (t_clr0 < 0) t_clr0 = cyc;
        chk("clr_y_empty", out_valid, 0);
        chk("clr_x_empty", en_act_out, 0);
        chk("clr_ch", ch_idx, c);
      end
      if (ch_done) begin
        n_chd++;
        chk("chdone_ch", ch_idx, c);
`ifdef RELU_NEG_CNT_EN
        chk("neg_cnt_ch", neg_cnt, last_neg);
`endif
      end
      if (done) begin
        n_done++;
        t_done = cyc;
        chk("done_all_in", c, NUM_CH);
        chk("done_q_empty", q.size(), 0);
`ifdef RELU_NEG_CNT_EN
        chk("neg_cnt_done", neg_cnt, last_neg);
`endif
      end
    end else prev_stall = 0;
  end

  task automatic drive(input int pv, input int pr, input int mode, input int t, input bit glitch);
    case (mode)
      1:       begin in_valid = (t % 2 == 0); out_ready = 1; end
      2:       begin in_valid = 1; out_ready = !(t >= 3 && t < 6); end
      default: begin
        in_valid  = ($urandom_range(0, 99) < pv);
        out_ready = ($urandom_range(0, 99) < pr);
      end
    endcase
    din = (fq.size() > 0) ? 8'(fq[0]) : 8'($urandom_range(0, 15) - 8);
    in_neg = (din < 0);
    start = glitch && (t == 4);
  endtask

  // One complete run: mode 0 random, 1 toggling valid, 2 mid-channel stall.
  task automatic run(input int pv, input int pr, input int mode, input bit glitch);
    int n0, nchd0, t;
    n0 = n_done; nchd0 = n_chd;
    k = 0; c = 0; neg_acc = 0; t_clr0 = -1; t_done = -1;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk("busy_run", busy, 1);
    chk("act_clr_first", act_clr, 1);
    chk("ch_idx_first", ch_idx, 0);
    t = 0;
    while (!done && t < 600) begin
      drive(pv, pr, mode, t, glitch);
      @(posedge clk); #1;
      t++;
    end
    if (t >= 600) chk("run_timeout", t, 0);
    if (glitch) begin
      start = 1;
      @(posedge clk); #1 start = 0;
    end
    in_valid = 0; out_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("done_once", n_done - n0, 1);
    chk("ch_done_cnt", n_chd - nchd0, NUM_CH - 1);
    chk("busy_after", busy, 0);
    chk("ch_idx_after", ch_idx, 0);
    if (mode == 0 && pv == 100 && pr == 100 && !glitch)
      chk("no_bubbles", t_done - t_clr0, NUM_CH * (MAP_LEN + 3));
  endtask

  task automatic reset_outputs_zero(input string name);
    chk(name, {busy, done, ch_done, act_clr, out_valid, out_last, in_ready, en_act, en_act_out, ch_idx}, 0);
  endtask

  task automatic reset_mid_run();
    int t;
    k = 0; c = 0; neg_acc = 0; t_clr0 = -1;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    in_valid = 1; out_ready = 0;
    t = 0;
    while (k < 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("accept_timeout", t, 0);
    #1 clr = 0;
    #1 reset_outputs_zero("async_reset");
    q.delete(); fq.delete();
    k = 0; c = 0; neg_acc = 0;
    in_valid = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #2 clr = 1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_outputs_zero("reset_state");
    clr = 1;
    fq = '{-3, 5, -1, 0};
    run(100, 100, 0, 0);
    run(100, 100, 2, 0);
    run(100, 100, 1, 0);
    reset_mid_run();
    run(100, 100, 0, 0);
    run(100, 100, 0, 1);
    repeat (6) run($urandom_range(30, 100), $urandom_range(30, 100), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/relu_stream_ctrl.md
Name: relu_stream_ctrl

Overview:
- Sequencing controller for the 2-stage ReLU activation unit (input register X, output register Y, controls clr/en_act/en_act_out).
- Runs a valid/ready stream of conv results through the unit, one feature map per channel, for NUM_CH channels.
- Handles downstream backpressure, per-channel clearing, and last/done signalling.
- Sits between the conv accumulator output and the pooling/buffer stage.

Parameters:
- MAP_LEN, 784, elements per feature map (28x28); must be at least 2.
- NUM_CH, 8, channels per run.
- CNT_W, 16, element counter width; 2^CNT_W must be greater than MAP_LEN.
- CH_W, 4, channel index width; 2^CH_W must be at least NUM_CH.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- start  in  1  begin run; sampled in IDLE only.
- busy  out  1  high in CLR/RUN/DRAIN.
- done  out  1  one-cycle pulse, run complete.
- ch_done  out  1  one-cycle pulse per finished channel, except the last.
- ch_idx  out  CH_W  current channel.
- in_valid  in  1  upstream element valid.
- in_ready  out  1  controller accepts element (combinational).
- in_neg  in  1  sign bit of current element; used only by the optional feature.
- out_valid  out  1  ReLU Y holds valid data.
- out_ready  in  1  downstream accepts Y.
- out_last  out  1  with out_valid: last element of the channel.
- act_clr  out  1  sync clear to ReLU, active-high, registered.
- en_act  out  1  ReLU X load (combinational).
- en_act_out  out  1  ReLU Y load (combinational).

Behaviour:
- Reset (clr=0, async):
  - state=IDLE; xv=yv=0; in_cnt=out_cnt=0; ch_idx=0.
  - busy, done, ch_done, act_clr all 0.
  - Mid-run reset abandons the run; it is not resumed.
- Pipeline valid bits: xv marks X valid, yv marks Y valid.
- Handshake equations:
  - y_take = yv & out_ready.
  - en_act_out = xv & (~yv | out_ready).
  - in_ready = (state==RUN) & (~xv | en_act_out).
  - en_act = in_valid & in_ready.
  - out_valid = yv.
  - out_last = yv & (out_cnt==MAP_LEN-1).
- Valid-bit updates:
  - xv next = en_act | (xv & ~en_act_out).
  - yv next = en_act_out | (yv & ~out_ready).
- Latency: an element accepted at edge N reaches Y at edge N+1 at the earliest; no bubbles under continuous valid/ready. Y and X hold while stalled.
- FSM:
  - IDLE: start=1 -> CLR. start in any other state is ignored.
  - CLR (1 cycle): act_clr=1; in_cnt=out_cnt=0 -> RUN.
  - RUN: each en_act increments in_cnt. en_act with in_cnt==MAP_LEN-1 -> DRAIN.
  - DRAIN: no input accepted. Each y_take increments out_cnt, also during RUN.
  - On y_take with out_cnt==MAP_LEN-1:
    - if ch_idx<NUM_CH-1: ch_done=1 next cycle, ch_idx++, -> CLR.
    - else -> DONE.
  - DONE (1 cycle): done=1, ch_idx=0 -> IDLE.
- Boundaries:
  - in_cnt and out_cnt never wrap within a channel.
  - Simultaneous en_act and y_take in the same cycle are both counted.
  - act_clr is never asserted while xv or yv is 1.
  - out_ready held low in DRAIN stalls indefinitely with Y held.

Optional Feature:
- Macro: RELU_NEG_CNT_EN.
- Defined: adds output neg_cnt [CNT_W-1:0].
  - Increments on en_act & in_neg; cleared in CLR.
  - Frozen and readable from the ch_done/done pulse until the next CLR.
- Undefined: neg_cnt port and logic absent; in_neg unused.

Test Plan:
- MAP_LEN=4, NUM_CH=2, in_valid and out_ready tied high, start pulse:
  - act_clr high 1 cycle, then 4 accepts on consecutive cycles.
  - out_valid 4 cycles with out_last on the 4th.
  - ch_done pulse, ch_idx=1, second channel repeats, then done pulse; busy low afterwards.
- out_ready low for 3 cycles mid-channel:
  - Y held stable.
  - in_ready drops once xv and yv are both 1.
  - No element lost or duplicated; out_cnt ends at 4.
- in_valid toggling 1,0,1,0:
  - en_act only on valid cycles.
  - Output order preserved; out_last on element 4.
- Async reset in RUN after 2 accepts:
  - All outputs 0 immediately.
  - start afterwards begins at ch_idx=0 with act_clr.
- start asserted during RUN and in DONE: ignored; exactly one run completes.
- RELU_NEG_CNT_EN defined, inputs -3,5,-1,0: neg_cnt=2 at ch_done; outputs 0,5,0,0.
